// File: rtl/isqrt_sched.sv
// isqrt_sched: round-robin front end that shares one sequential integer square-root
// engine among NCHAN requesters, with a watchdog on the engine completion strobe.
module isqrt_sched #(
   parameter int NCHAN      = 4,
   parameter int X_WIDTH    = 32,
   parameter int Y_WIDTH    = X_WIDTH / 2,
   parameter int TMO_CYCLES = Y_WIDTH + 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCHAN-1:0]         req_valid,
   input  logic [NCHAN*X_WIDTH-1:0] req_x,
   output logic [NCHAN-1:0]         req_ready,
   output logic                     res_valid,
   output logic [Y_WIDTH-1:0]       res_y,
   output logic [$clog2(NCHAN)-1:0] res_chan,
   output logic                     res_err,
   output logic                     busy,
   output logic                     sq_en,
   output logic [X_WIDTH-1:0]       sq_x,
   input  logic [Y_WIDTH-1:0]       sq_y,
   input  logic                     sq_dav
);
   localparam int CW = $clog2(NCHAN);
   localparam int TW = $clog2(TMO_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   state_t             state_q;
   logic [CW-1:0]      last_q;
   logic [TW-1:0]      wdog_q;
   logic               res_valid_q;
   logic [Y_WIDTH-1:0] res_y_q;
   logic [CW-1:0]      res_chan_q;
   logic               res_err_q;
   logic               busy_q;
   logic               sq_en_q;
   logic [X_WIDTH-1:0] sq_x_q;

   logic [X_WIDTH-1:0] x_arr [NCHAN];
   logic               gnt_any;
   logic [CW-1:0]      gnt_idx;

   genvar k;
   generate
      for (k = 0; k < NCHAN; k++) begin : g_slice
         assign x_arr[k] = req_x[k*X_WIDTH +: X_WIDTH];
      end
   endgenerate

   // Search starts just after the last granted channel so every requester is
   // served within NCHAN-1 foreign operations.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = last_q;
      for (int i = 1; i <= NCHAN; i++) begin
         idx = (int'(last_q) + i) % NCHAN;
         if (!gnt_any && req_valid[CW'(idx)]) begin
            gnt_any = 1'b1;
            gnt_idx = CW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_q      <= CW'(NCHAN - 1);
         wdog_q      <= '0;
         res_valid_q <= 1'b0;
         res_y_q     <= '0;
         res_chan_q  <= '0;
         res_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         sq_en_q     <= 1'b0;
         sq_x_q      <= '0;
      end else begin
         sq_en_q     <= 1'b0;
         res_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (gnt_any) begin
                  sq_x_q  <= x_arr[gnt_idx];
                  last_q  <= gnt_idx;
                  busy_q  <= 1'b1;
                  sq_en_q <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wdog_q  <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // A completion landing on the timeout cycle still wins.
               if (sq_dav) begin
                  res_y_q     <= sq_y;
                  res_err_q   <= 1'b0;
                  res_chan_q  <= last_q;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (wdog_q == TMO_LAST) begin
                  res_y_q     <= '0;
                  res_err_q   <= 1'b1;
                  res_chan_q  <= last_q;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign res_y     = res_y_q;
   assign res_chan  = res_chan_q;
   assign res_err   = res_err_q;
   assign busy      = busy_q;
   assign sq_en     = sq_en_q;
   assign sq_x      = sq_x_q;

endmodule

// File: tb/tb_isqrt_sched.sv
// Directed bench for isqrt_sched: behavioural sqrt engine with mute and strobe
// injection, one task per scenario, hand-computed expectations.
module tb_isqrt_sched;
   localparam int NCH = 4;
   localparam int XW  = 32;
   localparam int YW  = 16;
   localparam int TMO = YW + 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NCH-1:0]   req_valid = '0;
   logic [NCH*XW-1:0] req_x = '0;
   logic [NCH-1:0]   req_ready;
   logic             res_valid;
   logic [YW-1:0]    res_y;
   logic [1:0]       res_chan;
   logic             res_err;
   logic             busy;
   logic             sq_en;
   logic [XW-1:0]    sq_x;
   logic [YW-1:0]    sq_y;
   logic             sq_dav;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic          inj = 1'b0;
   logic [YW-1:0] inj_y = '0;
   logic          mute = 1'b0;

   isqrt_sched #(.NCHAN(NCH), .X_WIDTH(XW), .Y_WIDTH(YW), .TMO_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
      .req_ready(req_ready), .res_valid(res_valid), .res_y(res_y),
      .res_chan(res_chan), .res_err(res_err), .busy(busy), .sq_en(sq_en),
      .sq_x(sq_x), .sq_y(sq_y), .sq_dav(sq_dav)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: dav exactly YW+1 cycles after the sq_en cycle, restarts on sq_en.
   function automatic logic [YW-1:0] isqrt32(input logic [XW-1:0] x);
      logic [YW-1:0] yy;
      logic [63:0]   t;
      yy = '0;
      for (int b = YW - 1; b >= 0; b--) begin
         t = {48'b0, yy | (16'd1 << b)};
         if (t * t <= {32'b0, x}) yy = t[YW-1:0];
      end
      return yy;
   endfunction

   logic          eng_run = 1'b0;
   int            eng_cnt = 0;
   logic [XW-1:0] eng_x = '0;
   logic          eng_dav = 1'b0;
   logic [YW-1:0] eng_y = '0;

   always @(posedge clk) begin
      eng_dav <= 1'b0;
      if (sq_en) begin
         eng_run <= 1'b1;
         eng_cnt <= YW;
         eng_x   <= sq_x;
      end else if (eng_run) begin
         if (eng_cnt == 1) begin
            eng_run <= 1'b0;
            eng_dav <= 1'b1;
            eng_y   <= isqrt32(eng_x);
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   assign sq_dav = (eng_dav & ~mute) | inj;
   assign sq_y   = inj ? inj_y : eng_y;

   int             g, r, en_c, n;
   logic [NCH-1:0] gv;
   logic [XW-1:0]  sx;
   logic [YW-1:0]  y;
   logic [1:0]     ch;
   logic           e;

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int gc, output logic [NCH-1:0] gvec);
      gc = -1;
      gvec = '0;
      #1;
      for (int i = 0; i < 200; i++) begin
         if (req_ready != '0) begin
            gc = cyc;
            gvec = req_ready;
            return;
         end
         wait_cycle();
      end
   endtask

   task automatic wait_res(input int gc, input int inj_off, input logic [YW-1:0] iy,
                           output int rc, output int ec, output logic [XW-1:0] sxo,
                           output logic [YW-1:0] yo, output logic [1:0] cho, output logic eo);
      rc = -1; ec = -1; sxo = '0; yo = '0; cho = '0; eo = 1'b0;
      for (int i = 0; i < 200; i++) begin
         wait_cycle();
         if (sq_en && ec < 0) begin
            ec = cyc;
            sxo = sq_x;
         end
         if (res_valid) begin
            rc = cyc; yo = res_y; cho = res_chan; eo = res_err;
            inj = 1'b0;
            return;
         end
         inj_y = iy;
         inj = (inj_off >= 0) && (cyc - gc == inj_off);
      end
      inj = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) wait_cycle();
      checks++;
      if ({req_ready, res_valid, busy, sq_en, res_err} !== '0) begin
         errors++; $display("FAIL reset_ctl got %b want 0", {req_ready, res_valid, busy, sq_en, res_err});
      end
      checks++;
      if ({sq_x, res_y, res_chan} !== '0) begin
         errors++; $display("FAIL reset_data got %h want 0", {sq_x, res_y, res_chan});
      end
      rst_n = 1'b1;
      repeat (2) wait_cycle();
      checks++;
      if ({req_ready, res_valid, busy, sq_en} !== '0) begin
         errors++; $display("FAIL idle_after_reset got %b want 0", {req_ready, res_valid, busy, sq_en});
      end
   endtask

   task automatic test_single();
      req_x[2*XW +: XW] = 32'd1000000;
      req_valid = 4'b0100;
      wait_grant(g, gv);
      checks++;
      if (gv !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", gv); end
      wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
      req_valid = '0;
      checks++;
      if (en_c - g !== 1) begin errors++; $display("FAIL single_en_lat got %0d want 1", en_c - g); end
      checks++;
      if (sx !== 32'd1000000) begin errors++; $display("FAIL single_sq_x got %0d want 1000000", sx); end
      checks++;
      if (r - g !== 19) begin errors++; $display("FAIL single_res_lat got %0d want 19", r - g); end
      checks++;
      if ({y, ch, e} !== {16'd1000, 2'd2, 1'b0}) begin
         errors++; $display("FAIL single_res got y=%0d ch=%0d err=%0d want 1000 2 0", y, ch, e);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done got %b want 1", busy); end
      wait_cycle();
      checks++;
      if ({busy, res_valid} !== 2'b00) begin
         errors++; $display("FAIL single_after got %b want 00", {busy, res_valid});
      end
   endtask

   task automatic test_boundary();
      logic [XW-1:0] xs [4];
      logic [YW-1:0] ys [4];
      int prev;
      xs[0] = 32'd0;          ys[0] = 16'd0;
      xs[1] = 32'd99;         ys[1] = 16'd9;
      xs[2] = 32'hFFFF_FFFF;  ys[2] = 16'd65535;
      xs[3] = 32'd1;          ys[3] = 16'd1;
      prev = -1;
      req_x[0 +: XW] = xs[0];
      req_valid = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         wait_grant(g, gv);
         wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
         checks++;
         if ({y, ch, e} !== {ys[i], 2'd0, 1'b0}) begin
            errors++; $display("FAIL bound_res[%0d] got y=%0d ch=%0d err=%0d want %0d 0 0", i, y, ch, e, ys[i]);
         end
         if (i > 0) begin
            checks++;
            if (r - prev !== 20) begin errors++; $display("FAIL bound_gap[%0d] got %0d want 20", i, r - prev); end
         end
         prev = r;
         if (i < 3) req_x[0 +: XW] = xs[i+1];
         else req_valid = '0;
      end
   endtask

   task automatic test_round_robin();
      logic [NCH-1:0] eg;
      rst_n = 1'b0;
      wait_cycle();
      rst_n = 1'b1;
      wait_cycle();
      for (int k = 0; k < NCH; k++) req_x[k*XW +: XW] = (k + 4) * (k + 4);
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         eg = 4'b0001 << (i % 4);
         wait_grant(g, gv);
         checks++;
         if (gv !== eg) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, gv, eg); end
         wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
         if (i == 5) req_valid = '0;
         checks++;
         if ({y, ch, e} !== {16'((i % 4) + 4), 2'(i % 4), 1'b0}) begin
            errors++; $display("FAIL rr_res[%0d] got y=%0d ch=%0d err=%0d want %0d %0d 0", i, y, ch, e, (i % 4) + 4, i % 4);
         end
      end
   endtask

   task automatic test_timeout();
      mute = 1'b1;
      req_x[1*XW +: XW] = 32'd12345;
      req_valid = 4'b0010;
      wait_grant(g, gv);
      wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
      req_valid = '0;
      checks++;
      if (r - g !== 2 + TMO) begin errors++; $display("FAIL tmo_lat got %0d want %0d", r - g, 2 + TMO); end
      checks++;
      if ({y, e, ch} !== {16'd0, 1'b1, 2'd1}) begin
         errors++; $display("FAIL tmo_res got y=%0d err=%0d ch=%0d want 0 1 1", y, e, ch);
      end
      // completion on the very cycle the watchdog expires
      req_valid = 4'b0010;
      wait_grant(g, gv);
      wait_res(g, 1 + TMO, 16'h0ABC, r, en_c, sx, y, ch, e);
      req_valid = '0;
      checks++;
      if (r - g !== 2 + TMO) begin errors++; $display("FAIL tie_lat got %0d want %0d", r - g, 2 + TMO); end
      checks++;
      if ({y, e, ch} !== {16'h0ABC, 1'b0, 2'd1}) begin
         errors++; $display("FAIL tie_res got y=%h err=%0d ch=%0d want 0abc 0 1", y, e, ch);
      end
      mute = 1'b0;
      req_x[2*XW +: XW] = 32'd144;
      req_valid = 4'b0100;
      wait_grant(g, gv);
      wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
      req_valid = '0;
      checks++;
      if (r - g !== 19) begin errors++; $display("FAIL post_tmo_lat got %0d want 19", r - g); end
      checks++;
      if ({y, ch, e} !== {16'd12, 2'd2, 1'b0}) begin
         errors++; $display("FAIL post_tmo_res got y=%0d ch=%0d err=%0d want 12 2 0", y, ch, e);
      end
   endtask

   task automatic test_reset_mid();
      req_x[1*XW +: XW] = 32'd400;
      req_valid = 4'b0010;
      wait_grant(g, gv);
      wait_cycle();
      req_valid = '0;
      repeat (4) wait_cycle();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, sq_en, res_valid, req_ready} !== '0) begin
         errors++; $display("FAIL mid_reset_clear got %b want 0", {busy, sq_en, res_valid, req_ready});
      end
      wait_cycle();
      wait_cycle();
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         wait_cycle();
         if (res_valid || busy) n++;
      end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL mid_reset_stray got %0d want 0", n); end
      req_x[0 +: XW] = 32'd9;
      req_x[3*XW +: XW] = 32'd10000;
      req_valid = 4'b1001;
      wait_grant(g, gv);
      checks++;
      if (gv !== 4'b0001) begin errors++; $display("FAIL mid_reset_ptr got %b want 0001", gv); end
      wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
      req_valid = 4'b1000;
      checks++;
      if ({y, ch, e} !== {16'd3, 2'd0, 1'b0}) begin
         errors++; $display("FAIL mid_reset_ch0 got y=%0d ch=%0d err=%0d want 3 0 0", y, ch, e);
      end
      wait_grant(g, gv);
      checks++;
      if (gv !== 4'b1000) begin errors++; $display("FAIL mid_reset_g3 got %b want 1000", gv); end
      wait_res(g, -1, '0, r, en_c, sx, y, ch, e);
      req_valid = '0;
      checks++;
      if (r - g !== 19) begin errors++; $display("FAIL mid_reset_lat got %0d want 19", r - g); end
      checks++;
      if ({y, ch, e} !== {16'd100, 2'd3, 1'b0}) begin
         errors++; $display("FAIL mid_reset_ch3 got y=%0d ch=%0d err=%0d want 100 3 0", y, ch, e);
      end
   endtask

   task automatic test_spurious();
      wait_cycle();
      inj_y = 16'h5555;
      inj = 1'b1;
      wait_cycle();
      inj = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         wait_cycle();
         if (res_valid || busy || sq_en) n++;
      end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL spur_idle got %0d want 0", n); end
      req_x[2*XW +: XW] = 32'd2500;
      req_valid = 4'b0100;
      wait_grant(g, gv);
      wait_res(g, 1, 16'h1234, r, en_c, sx, y, ch, e);
      req_valid = '0;
      checks++;
      if (r - g !== 19) begin errors++; $display("FAIL spur_launch_lat got %0d want 19", r - g); end
      checks++;
      if ({y, ch, e} !== {16'd50, 2'd2, 1'b0}) begin
         errors++; $display("FAIL spur_launch_res got y=%0d ch=%0d err=%0d want 50 2 0", y, ch, e);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      test_spurious();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isqrt_sched.md
Name: isqrt_sched

Overview:
- Round-robin scheduler that shares one non-pipelined sequential integer square-root engine among NCHAN requesters.
- Sits between per-channel magnitude producers (e.g. I²+Q² power words) and the single sqrt engine.
- Per request: grants one channel, launches the engine, captures its one-cycle result, and returns the result tagged with the channel number.
- A watchdog aborts any operation whose completion strobe never arrives.

Parameters:
- NCHAN, 4, number of requesting channels (2..16).
- X_WIDTH, 32, radicand width; must be even.
- Y_WIDTH, X_WIDTH/2, result width.
- TMO_CYCLES, Y_WIDTH+4, cycles after engine launch before the watchdog aborts.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NCHAN  per-channel request; level, held until granted.
- req_x  in  NCHAN*X_WIDTH  packed radicands; channel k at [k*X_WIDTH +: X_WIDTH].
- req_ready  out  NCHAN  one-hot grant strobe; one cycle; radicand sampled this cycle.
- res_valid  out  1  one-cycle result strobe.
- res_y  out  Y_WIDTH  result, truncated sqrt; valid with res_valid.
- res_chan  out  clog2(NCHAN)  channel the result belongs to.
- res_err  out  1  with res_valid: 1 = watchdog abort, res_y forced 0.
- busy  out  1  high from grant through result cycle.
- sq_en  out  1  engine start strobe; one cycle.
- sq_x  out  X_WIDTH  engine radicand; registered, stable while sq_en high.
- sq_y  in  Y_WIDTH  engine result; valid only in the sq_dav cycle.
- sq_dav  in  1  engine completion strobe; one cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pointer last=NCHAN-1; outputs req_ready, res_valid, res_y, res_chan, res_err, busy, sq_en, sq_x all 0.
- Engine contract:
  - sq_en high for one cycle E.
  - sq_dav is high exactly in cycle E+Y_WIDTH+1; sq_y is valid only in that cycle.
  - Engine restarts on any sq_en.
- States IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req_valid, grant the first asserted channel searching last+1, last+2, ... modulo NCHAN.
  - In the same cycle: req_ready[k]=1 (combinational from registered state), sq_x<=req_x[k], last<=k, busy<=1, go to LAUNCH.
  - No request: stay.
- LAUNCH: sq_en=1 for exactly this cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - sq_dav sampled from the cycle after LAUNCH.
  - On sq_dav: capture res_y<=sq_y, res_err<=0, go to DONE.
  - Watchdog counts cycles in WAIT. On reaching TMO_CYCLES: res_y<=0, res_err<=1, go to DONE.
  - sq_dav arriving together with the timeout counts as a success.
- DONE: res_valid=1 and res_chan=last for this cycle; busy drops at the end of the cycle; go to IDLE.
- Latency:
  - Grant cycle G, sq_en at G+1, sq_dav at G+Y_WIDTH+2, res_valid at G+Y_WIDTH+3 (G+19 for Y_WIDTH=16).
  - Next grant no earlier than G+Y_WIDTH+4.
- Stray inputs: sq_dav outside WAIT is ignored. req_valid changes outside IDLE are ignored.
- Only one req_ready bit is ever high. A grant never happens while busy.
- Fairness: a continuously requesting channel waits at most NCHAN-1 other operations.
- Reset mid-operation: all state cleared immediately, sq_en low, pending result discarded. The engine may finish its internal run afterwards; that sq_dav is ignored because the scheduler is in IDLE.
- Widths: sq_x zero-extended from req_x slice; res_chan = index, not one-hot.

Test Plan:
- Single request, ch2, x=1000000 -> req_ready=0100 at G, sq_en at G+1, res_valid at G+19, res_y=1000, res_chan=2, res_err=0.
- Boundary radicands: x=0 -> 0; x=99 -> 9; x=0xFFFFFFFF -> 65535; x=1 -> 1; all on ch0 back-to-back. Each result arrives 20 cycles after the previous one.
- All four channels requesting continuously from reset -> grant order 0,1,2,3,0,…; results tagged in the same order with correct values.
- Engine model that never asserts sq_dav, ch1 -> res_valid at G+2+TMO_CYCLES with res_err=1, res_y=0. Next grant proceeds normally.
- rst_n pulsed low during WAIT, then ch3 request after release -> no result for the aborted op. Stray sq_dav ignored. ch3 result correct with normal latency. Pointer restarts so ch0 has priority first.
- Spurious sq_dav injected in IDLE and in LAUNCH -> no res_valid, state unchanged.
